// File: rtl/cpu_pkg.sv
// Shared types and constants for the cpu_ctrl sequencer: opcodes, FSM states,
// instruction field positions and the ALU operation codes.
package cpu_pkg;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_LDI  = 4'h6,
    OP_MOV  = 4'h7,
    OP_JMP  = 4'h8,
    OP_BEQZ = 4'h9,
    OP_HALT = 4'hF
  } op_t;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALT      = 3'd4
  } state_t;

  // ALU codes; the ALU decodes these same values
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_XOR   = 3'd4;
  localparam logic [2:0] ALU_PASSA = 3'd5;

endpackage

// File: rtl/cpu_decode.sv
// Combinational instruction decoder: splits the IR into register/immediate
// fields and classifies the opcode for the control FSM.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [15:0] ir_i,
  output logic [3:0]  rd_o,
  output logic [3:0]  rs1_o,
  output logic [3:0]  rs2_o,
  output logic [7:0]  imm_o,
  output logic [2:0]  alu_op_o,
  output logic        wb_sel_o,
  output logic        writes_reg_o,
  output logic        is_jmp_o,
  output logic        is_beqz_o,
  output logic        is_halt_o,
  output logic        is_illegal_o
);

  assign rd_o  = ir_i[RD_MSB:RD_LSB];
  assign rs1_o = ir_i[RS1_MSB:RS1_LSB];
  assign rs2_o = ir_i[RS2_MSB:RS2_LSB];
  assign imm_o = ir_i[IMM_MSB:IMM_LSB];

  always_comb begin
    alu_op_o     = ALU_ADD;
    wb_sel_o     = 1'b0;
    writes_reg_o = 1'b0;
    is_jmp_o     = 1'b0;
    is_beqz_o    = 1'b0;
    is_halt_o    = 1'b0;
    is_illegal_o = 1'b0;
    case (op_t'(ir_i[OP_MSB:OP_LSB]))
      OP_NOP:  ;
      OP_ADD:  begin writes_reg_o = 1'b1; alu_op_o = ALU_ADD;   end
      OP_SUB:  begin writes_reg_o = 1'b1; alu_op_o = ALU_SUB;   end
      OP_AND:  begin writes_reg_o = 1'b1; alu_op_o = ALU_AND;   end
      OP_OR:   begin writes_reg_o = 1'b1; alu_op_o = ALU_OR;    end
      OP_XOR:  begin writes_reg_o = 1'b1; alu_op_o = ALU_XOR;   end
      OP_LDI:  begin writes_reg_o = 1'b1; wb_sel_o = 1'b1;      end
      OP_MOV:  begin writes_reg_o = 1'b1; alu_op_o = ALU_PASSA; end
      OP_JMP:  is_jmp_o  = 1'b1;
      OP_BEQZ: is_beqz_o = 1'b1;
      OP_HALT: is_halt_o = 1'b1;
      default: is_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control sequencer: fetches 16-bit instructions, drives the
// register-file / ALU controls and maintains the program counter.
//
//   state        | meaning
//   -------------+--------------------------------------------------------
//   ST_FETCH     | instr_req high, wait for instr_valid, capture IR
//   ST_DECODE    | register addresses driven from IR, read data settles
//   ST_EXECUTE   | resolve branch/jump/halt, or move on to write-back
//   ST_WRITEBACK | one-cycle register-file write strobe, PC+1
//   ST_HALT      | terminal until RST
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               CLK,
  input  logic               RST,
  output logic               instr_req,
  output logic [PC_W-1:0]    instr_addr,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr_data,
  output logic [3:0]         RA1,
  output logic [3:0]         RA2,
  output logic [3:0]         WA,
  output logic               write_enable,
  output logic [2:0]         alu_op,
  output logic               wb_sel,
  output logic [7:0]         imm,
  input  logic [7:0]         RD1,
  output logic               halted,
  output logic               illegal
);

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               halted_q, halted_d;
  logic               illegal_q, illegal_d;

  logic [3:0] dec_rd, dec_rs1, dec_rs2;
  logic [7:0] dec_imm;
  logic [2:0] dec_alu_op;
  logic       dec_wb_sel, dec_writes_reg, dec_is_jmp, dec_is_beqz;
  logic       dec_is_halt, dec_is_illegal;

  cpu_decode u_decode (
    .ir_i         (ir_q),
    .rd_o         (dec_rd),
    .rs1_o        (dec_rs1),
    .rs2_o        (dec_rs2),
    .imm_o        (dec_imm),
    .alu_op_o     (dec_alu_op),
    .wb_sel_o     (dec_wb_sel),
    .writes_reg_o (dec_writes_reg),
    .is_jmp_o     (dec_is_jmp),
    .is_beqz_o    (dec_is_beqz),
    .is_halt_o    (dec_is_halt),
    .is_illegal_o (dec_is_illegal)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    halted_d     = halted_q;
    illegal_d    = illegal_q;
    instr_req    = 1'b0;
    write_enable = 1'b0;
    case (state_q)
      ST_FETCH: begin
        instr_req = 1'b1;
        if (instr_valid) begin
          ir_d    = instr_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        illegal_d = illegal_q | dec_is_illegal;
        if (dec_is_halt) begin
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else if (dec_writes_reg) begin
          state_d = ST_WRITEBACK;
        end else if (dec_is_jmp || (dec_is_beqz && (RD1 == 8'h00))) begin
          pc_d    = PC_W'(dec_imm);
          state_d = ST_FETCH;
        end else begin
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_FETCH;
        end
      end
      ST_WRITEBACK: begin
        write_enable = 1'b1;
        pc_d         = pc_q + PC_W'(1);
        state_d      = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // BEQZ tests the register named in the rd field, so it reads it on port 1
  assign RA1        = dec_is_beqz ? dec_rd : dec_rs1;
  assign RA2        = dec_rs2;
  assign WA         = dec_rd;
  assign alu_op     = dec_alu_op;
  assign wb_sel     = dec_wb_sel;
  assign imm        = dec_imm;
  assign instr_addr = pc_q;
  assign halted     = halted_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: instruction memory responder, register file + ALU,
// a transaction-level architectural model and a per-cycle compare process.
module tb_cpu_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        instr_req;
  logic [7:0]  instr_addr;
  logic        instr_valid = 1'b0;
  logic [15:0] instr_data = 16'h0000;
  logic [3:0]  RA1, RA2, WA;
  logic        write_enable;
  logic [2:0]  alu_op;
  logic        wb_sel;
  logic [7:0]  imm, RD1;
  logic        halted, illegal;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 CLK = ~CLK;

  cpu_ctrl #(.PC_W(8), .INSTR_W(16)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .instr_req    (instr_req),
    .instr_addr   (instr_addr),
    .instr_valid  (instr_valid),
    .instr_data   (instr_data),
    .RA1          (RA1),
    .RA2          (RA2),
    .WA           (WA),
    .write_enable (write_enable),
    .alu_op       (alu_op),
    .wb_sel       (wb_sel),
    .imm          (imm),
    .RD1          (RD1),
    .halted       (halted),
    .illegal      (illegal)
  );

  // register file and ALU around the controller
  logic [7:0] rf [16] = '{default: 8'h00};
  logic [7:0] rd2, alu_y, wdata;
  assign RD1 = rf[RA1];
  assign rd2 = rf[RA2];
  always_comb begin
    alu_y = 8'h00;
    case (alu_op)
      3'd0: alu_y = RD1 + rd2;
      3'd1: alu_y = RD1 - rd2;
      3'd2: alu_y = RD1 & rd2;
      3'd3: alu_y = RD1 | rd2;
      3'd4: alu_y = RD1 ^ rd2;
      3'd5: alu_y = RD1;
      default: alu_y = 8'h00;
    endcase
  end
  assign wdata = wb_sel ? imm : alu_y;
  always @(posedge CLK) if (write_enable) rf[WA] <= wdata;

  // instruction memory with programmable wait states; drives noise when not requested
  logic [15:0] imem [256];
  int wait_n = 0;
  bit noise  = 1'b0;

  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge CLK);
      if (instr_req === 1'b1) begin
        if (wcnt >= wait_n) begin
          instr_valid = 1'b1;
          instr_data  = imem[instr_addr];
        end else begin
          instr_valid = 1'b0;
          instr_data  = 16'h6FFF;
        end
        wcnt++;
      end else begin
        wcnt        = 0;
        instr_valid = noise;
        instr_data  = 16'h6EEE;
      end
    end
  end

  // architectural model: m_phase counts cycles since the instruction was accepted
  int         m_phase = 0;
  logic [7:0] m_pc = 8'h00, m_npc = 8'h00, m_wval = 8'h00, m_imm = 8'h00;
  logic [3:0] m_op = 4'h0, m_rd = 4'h0, m_rs1 = 4'h0, m_rs2 = 4'h0;
  bit         m_wr = 1'b0, m_halted = 1'b0, m_illegal = 1'b0;
  logic [7:0] m_rf [16] = '{default: 8'h00};

  initial begin
    forever begin
      @(posedge CLK);
      if (m_phase == 3) m_rf[m_rd] = m_wval;
      if (RST) begin
        m_phase = 0; m_pc = 8'h00; m_halted = 1'b0; m_illegal = 1'b0;
      end else if (!m_halted) begin
        case (m_phase)
          0: if (instr_valid) begin
            m_op  = instr_data[15:12];
            m_rd  = instr_data[11:8];
            m_rs1 = instr_data[7:4];
            m_rs2 = instr_data[3:0];
            m_imm = instr_data[7:0];
            m_wr  = (m_op >= 4'h1) && (m_op <= 4'h7);
            case (m_op)
              4'h1: m_wval = m_rf[m_rs1] + m_rf[m_rs2];
              4'h2: m_wval = m_rf[m_rs1] - m_rf[m_rs2];
              4'h3: m_wval = m_rf[m_rs1] & m_rf[m_rs2];
              4'h4: m_wval = m_rf[m_rs1] | m_rf[m_rs2];
              4'h5: m_wval = m_rf[m_rs1] ^ m_rf[m_rs2];
              4'h6: m_wval = m_imm;
              4'h7: m_wval = m_rf[m_rs1];
              default: m_wval = 8'h00;
            endcase
            if (m_op == 4'h8 || (m_op == 4'h9 && m_rf[m_rd] == 8'h00)) m_npc = m_imm;
            else m_npc = m_pc + 8'd1;
            m_phase = 1;
          end
          1: m_phase = 2;
          2: begin
            if (m_op == 4'hF) m_halted = 1'b1;
            else begin
              if (m_op >= 4'hA && m_op <= 4'hE) m_illegal = 1'b1;
              if (m_wr) m_phase = 3;
              else begin m_pc = m_npc; m_phase = 0; end
            end
          end
          default: begin m_pc = m_npc; m_phase = 0; end
        endcase
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  initial begin
    logic [2:0] e_alu;
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        e_alu = (m_op == 4'h7) ? 3'd5 : 3'(m_op - 4'd1);
        chk("illegal", 32'(illegal), 32'(m_illegal));
        chk("halted", 32'(halted), 32'(m_halted));
        if (m_halted) begin
          chk("halt_req", 32'(instr_req), 0);
          chk("halt_we", 32'(write_enable), 0);
        end else begin
          chk("req", 32'(instr_req), 32'(m_phase == 0));
          chk("we", 32'(write_enable), 32'(m_phase == 3));
          if (m_phase == 0) chk("addr", 32'(instr_addr), 32'(m_pc));
          if (m_phase == 1) begin
            chk("ra1", 32'(RA1), 32'((m_op == 4'h9) ? m_rd : m_rs1));
            chk("ra2", 32'(RA2), 32'(m_rs2));
          end
          if (m_phase >= 1 && m_wr) begin
            chk("wa", 32'(WA), 32'(m_rd));
            chk("wb_sel", 32'(wb_sel), 32'(m_op == 4'h6));
            chk("imm", 32'(imm), 32'(m_imm));
            if (m_op != 4'h6) chk("alu_op", 32'(alu_op), 32'(e_alu));
          end
          if (m_phase == 3) chk("wdata", 32'(wdata), 32'(m_wval));
        end
      end
    end
  end

  task automatic wait_fetch(input logic [7:0] a, input int budget);
    int n;
    n = 0;
    @(negedge CLK);
    while (!(instr_req === 1'b1 && instr_addr === a) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL wait_fetch actual=timeout required=addr_%0h", a);
    end
  endtask

  initial begin
    int n;
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    imem[8'h00] = 16'h6115; imem[8'h01] = 16'h6227; imem[8'h02] = 16'h1312;
    imem[8'h03] = 16'h9440; imem[8'h40] = 16'h6401; imem[8'h41] = 16'h9450;
    imem[8'h42] = 16'h2531; imem[8'h43] = 16'h3632; imem[8'h44] = 16'h4712;
    imem[8'h45] = 16'h5812; imem[8'h46] = 16'h7930; imem[8'h47] = 16'h0000;
    imem[8'h48] = 16'hB123; imem[8'h49] = 16'h80FF; imem[8'hFF] = 16'h0000;
    noise = 1'b1;

    repeat (2) @(negedge CLK);
    chk_en = 1'b1;
    chk("rst_req", 32'(instr_req), 1);
    chk("rst_addr", 32'(instr_addr), 0);
    chk("rst_we", 32'(write_enable), 0);
    chk("rst_ra", 32'({RA1, RA2, WA}), 0);
    chk("rst_alu", 32'({alu_op, wb_sel}), 0);
    chk("rst_imm", 32'(imm), 0);
    chk("rst_flags", 32'({halted, illegal}), 0);
    RST = 1'b0;

    n = 0;
    while (write_enable !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
    chk("ldi_latency", n, 3);
    chk("ldi_wa", 32'(WA), 1);
    chk("ldi_wb_sel", 32'(wb_sel), 1);
    chk("ldi_imm", 32'(imm), 32'h15);

    wait_fetch(8'h01, 20);
    chk("ldi_pc", 32'(instr_addr), 1);
    wait_n = 5;
    wait_fetch(8'h02, 40);
    chk("r1", 32'(rf[1]), 32'h15);
    chk("r2", 32'(rf[2]), 32'h27);
    n = 1;
    while (n < 50) begin
      @(negedge CLK);
      if (instr_req === 1'b1 && instr_addr === 8'h02) n++;
      else break;
    end
    chk("fetch_hold", n, 6);
    chk("add_ra1", 32'(RA1), 1);
    chk("add_ra2", 32'(RA2), 2);
    chk("add_alu", 32'(alu_op), 0);
    wait_n = 0;

    wait_fetch(8'h40, 60);
    chk("r3", 32'(rf[3]), 32'h3C);
    wait_fetch(8'h42, 60);
    wait_fetch(8'h49, 100);
    chk("illegal_set", 32'(illegal), 1);
    chk("r5", 32'(rf[5]), 32'h27);
    chk("r6", 32'(rf[6]), 32'h24);
    chk("r7", 32'(rf[7]), 32'h37);
    chk("r8", 32'(rf[8]), 32'h32);
    chk("r9", 32'(rf[9]), 32'h3C);
    wait_fetch(8'hFF, 30);
    wait_fetch(8'h00, 30);

    // HALT
    RST = 1'b1;
    @(negedge CLK);
    imem[8'h00] = 16'hF000;
    @(negedge CLK);
    RST = 1'b0;
    n = 0;
    while (halted !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
    chk("halt_reached", 32'(n < 20), 1);
    repeat (20) @(negedge CLK);
    chk("halt_stay_req", 32'(instr_req), 0);
    chk("halt_stay", 32'(halted), 1);

    // reset during WRITEBACK, after an illegal opcode
    RST = 1'b1;
    @(negedge CLK);
    chk("unhalt", 32'(halted), 0);
    imem[8'h00] = 16'hC000;
    imem[8'h01] = 16'h6AAB;
    @(negedge CLK);
    RST = 1'b0;
    n = 0;
    while (write_enable !== 1'b1 && n < 30) begin @(negedge CLK); n++; end
    chk("wb_reached", 32'(n < 30), 1);
    chk("wb_illegal", 32'(illegal), 1);
    RST = 1'b1;
    @(negedge CLK);
    chk("wbrst_we", 32'(write_enable), 0);
    chk("wbrst_addr", 32'(instr_addr), 0);
    chk("wbrst_flags", 32'({halted, illegal}), 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    wait_fetch(8'h01, 30);
    wait_fetch(8'h02, 30);

    for (int r = 0; r < 16; r++) chk("rf_final", 32'(rf[r]), 32'(m_rf[r]));
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Multi-cycle control sequencer for the 8-bit datapath built around the 16 x 8-bit register file (two read ports, one write port). It fetches 16-bit instructions over a simple request/valid interface, decodes them, and drives the register-file addresses, write enable, ALU operation and write-back source select. It also maintains the program counter, including jumps and a conditional branch. It sits between instruction memory and the register file / ALU pair and is the only agent that writes the register file.

## Interface
Parameters:
- PC_W, 8, program counter / instruction address width
- INSTR_W, 16, instruction width; field layout below is fixed for 16

Ports:
- CLK  in  1  rising-edge clock; one clock for the whole block
- RST  in  1  synchronous, active-high reset
- instr_req  out  1  high while in FETCH
- instr_addr  out  PC_W  current PC; stable while instr_req high
- instr_valid  in  1  instruction memory has instr_data for instr_addr
- instr_data  in  16  instruction word
- RA1  out  4  register-file read address 1
- RA2  out  4  register-file read address 2
- WA  out  4  register-file write address
- write_enable  out  1  register-file write strobe
- alu_op  out  3  ALU operation code
- wb_sel  out  1  0 = write ALUResult, 1 = write imm
- imm  out  8  immediate, IR[7:0]
- RD1  in  8  register-file read data 1 (branch test)
- halted  out  1  sticky; set by HALT
- illegal  out  1  sticky; set by an undefined opcode

## Operation
- Instruction fields: op = IR[15:12], rd = IR[11:8], rs1 = IR[7:4], rs2 = IR[3:0], imm8 = IR[7:0].
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd <= rs1 op rs2; alu_op = op-1
  - 6 LDI: rd <= imm8
  - 7 MOV: rd <= rs1 via alu_op 5 (pass A)
  - 8 JMP: PC <= imm8
  - 9 BEQZ: if reg[IR[11:8]] == 0 then PC <= imm8; for BEQZ, RA1 = IR[11:8]
  - F HALT
  - A-E illegal: executed as NOP, sets illegal
- FSM states: FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
  - FETCH: instr_req = 1. On instr_valid: IR <= instr_data, go to DECODE. Otherwise stay.
  - DECODE: RA1/RA2 driven from IR, one cycle for read data to settle.
  - EXECUTE:
    - ALU ops, LDI, MOV: go to WRITEBACK.
    - JMP / taken BEQZ: PC <= imm8, go to FETCH.
    - NOP, illegal, not-taken BEQZ: PC <= PC+1, go to FETCH.
    - HALT: go to HALT.
  - WRITEBACK: write_enable = 1 for exactly one cycle, WA = rd; PC <= PC+1; go to FETCH.
  - HALT: terminal until RST; halted = 1, instr_req = 0, write_enable = 0.
- RA1, RA2, WA, alu_op, wb_sel and imm are decoded from IR, a register, so they are stable from DECODE through WRITEBACK.
- PC arithmetic is modulo 2^PC_W: 255+1 wraps to 0.
- instr_valid is ignored whenever instr_req is low.

## Timing
- Reset values: state FETCH, PC 0, IR 0, instr_req 1 (FETCH), instr_addr 0, RA1/RA2/WA 0, write_enable 0, alu_op 0, wb_sel 0, imm 0, halted 0, illegal 0.
- Latency from fetch acceptance:
  - Register-writing instructions: 3 cycles; the write occurs at the rising edge ending WRITEBACK.
  - Others: 2 cycles back to FETCH.
  - With zero-wait memory, 4 cycles/instruction (writing) or 3 (non-writing).
- Back-to-back dependency needs no forwarding: the WRITEBACK edge precedes the next DECODE.
- BEQZ samples RD1 in EXECUTE.
- RST asserted in any state, including mid-fetch or in WRITEBACK, takes effect at the next edge:
  - write_enable is 0 in the cycle after reset.
  - No partial write-back completes after the reset edge.
  - halted and illegal clear.
- An instruction arriving on the same edge as RST is discarded.

## Structure
- Package cpu_pkg holds:
  - opcode enum (op_t)
  - state enum (state_t)
  - field position constants
  - ALU op codes shared with the ALU
- One combinational sub-module, cpu_decode: IR to rd/rs1/rs2/imm/alu_op/wb_sel, plus class flags (writes_reg, is_jmp, is_beqz, is_halt, is_illegal).
- cpu_ctrl holds the FSM, PC and IR.

## Test plan
- Reset then LDI r1,0x15 (0x6115), zero-wait memory → write_enable pulses on cycle 3 after acceptance with WA=1, wb_sel=1, imm=0x15; PC=1.
- ADD r3,r1,r2 (0x1312) → in DECODE RA1=1, RA2=2; alu_op=0; WA=3 write strobe one cycle; instr_valid delayed 5 cycles holds FETCH with instr_addr stable.
- BEQZ r4,0x40 (0x9440): RD1=0 → next instr_addr=0x40; RD1=0x01 → next instr_addr=PC+1; write_enable never asserted.
- JMP 0xFF then NOP at 0xFF → next instr_addr 0x00 (wrap).
- Opcode 0xB → illegal=1, PC+1, no write; HALT (0xF000) → halted=1, instr_req=0 indefinitely.
- RST asserted during WRITEBACK → write_enable=0 next cycle, instr_addr=0, halted=0, illegal=0.
